// File: rtl/io_bridge_param.sv
// Byte-serial bridge between a single-cycle MIPS core and narrow I/O pins.
// Each step fetches one instruction word, pulses cpu_clk, then serialises address, store data and load data.
module io_bridge_param #(
    parameter int WORD_W      = 32,
    parameter int IO_W        = 8,
    parameter int ADDR_BEATS  = 4,
    parameter int TURN_CYCLES = 1,
    localparam int BEATS      = WORD_W / IO_W,
    localparam int CW         = $clog2(BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IO_W-1:0]   io_in,
    output logic [IO_W-1:0]   io_out,
    output logic              io_oe,
    output logic [1:0]        io_phase,
    output logic [CW-1:0]     io_beat,
    output logic              cpu_clk,
    input  logic              mem_w,
    input  logic              mem_r,
    input  logic              flow_chg,
    input  logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] wr_data,
    output logic [WORD_W-1:0] instruction,
    output logic              instr_valid,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    // The counter also times the turnaround gap, which may be longer than a word.
    localparam int KW = (CW > 3) ? CW : 3;
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [KW-1:0] BEAT_LAST = KW'(BEATS - 1);
    localparam logic [KW-1:0] ADDR_LAST = KW'(ADDR_BEATS - 1);
    localparam logic [KW-1:0] TURN_LAST = KW'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    localparam logic          HAS_TURN  = (TURN_CYCLES > 0);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_EXEC  = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_TURN  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;

    localparam logic [1:0] PH_FETCH = 2'b00;
    localparam logic [1:0] PH_ADDR  = 2'b01;
    localparam logic [1:0] PH_WDATA = 2'b10;
    localparam logic [1:0] PH_READ  = 2'b11;

    logic [2:0]        state_reg, state_next;
    logic [KW-1:0]     beat_reg, beat_next;
    logic [KW-1:0]     beat_limit;
    logic              last_beat;
    logic [IW-1:0]     beat_idx;

    logic [WORD_W-1:0] sh_addr_reg;
    logic [WORD_W-1:0] sh_wdata_reg;
    logic              sh_r_reg;
    logic              sh_w_reg;

    logic [WORD_W-1:0] instr_reg, instr_next;
    logic [WORD_W-1:0] rd_reg, rd_next;
    logic [IO_W-1:0]   io_out_reg, io_out_next;
    logic              io_oe_reg;
    logic [1:0]        io_phase_reg, io_phase_next;
    logic [CW-1:0]     io_beat_reg;
    logic              cpu_clk_reg;
    logic              instr_valid_reg;
    logic              rd_valid_reg;
    logic              busy_reg;

    logic [IO_W-1:0]   addr_beat  [BEATS];
    logic [IO_W-1:0]   wdata_beat [BEATS];

    assign beat_idx = beat_reg[IW-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign addr_beat[gi]  = sh_addr_reg[gi*IO_W +: IO_W];
            assign wdata_beat[gi] = sh_wdata_reg[gi*IO_W +: IO_W];
            assign instr_next[gi*IO_W +: IO_W] =
                (state_reg == S_FETCH && beat_idx == IW'(gi)) ? io_in : instr_reg[gi*IO_W +: IO_W];
            assign rd_next[gi*IO_W +: IO_W] =
                (state_reg == S_RDATA && beat_idx == IW'(gi)) ? io_in : rd_reg[gi*IO_W +: IO_W];
        end
    endgenerate

    always_comb begin
        beat_limit = '0;
        case (state_reg)
            S_FETCH: beat_limit = BEAT_LAST;
            S_ADDR:  beat_limit = ADDR_LAST;
            S_WDATA: beat_limit = BEAT_LAST;
            S_TURN:  beat_limit = TURN_LAST;
            S_RDATA: beat_limit = BEAT_LAST;
            default: beat_limit = '0;
        endcase
    end

    assign last_beat = (beat_reg == beat_limit);

    always_comb begin
        state_next = state_reg;
        beat_next  = last_beat ? '0 : beat_reg + 1'b1;
        case (state_reg)
            S_FETCH: if (last_beat) state_next = S_EXEC;
            S_EXEC:  state_next = (mem_w || mem_r || flow_chg) ? S_ADDR : S_FETCH;
            S_ADDR: begin
                if (last_beat) begin
                    if (sh_w_reg)      state_next = S_WDATA;
                    else if (sh_r_reg) state_next = HAS_TURN ? S_TURN : S_RDATA;
                    else               state_next = S_FETCH;
                end
            end
            S_WDATA: begin
                if (last_beat) begin
                    if (sh_r_reg) state_next = HAS_TURN ? S_TURN : S_RDATA;
                    else          state_next = S_FETCH;
                end
            end
            S_TURN:  if (last_beat) state_next = S_RDATA;
            S_RDATA: if (last_beat) state_next = S_FETCH;
            default: begin
                state_next = S_FETCH;
                beat_next  = '0;
            end
        endcase
    end

    always_comb begin
        io_out_next   = '0;
        io_phase_next = PH_FETCH;
        case (state_reg)
            S_ADDR: begin
                io_out_next   = addr_beat[beat_idx];
                io_phase_next = PH_ADDR;
            end
            S_WDATA: begin
                io_out_next   = wdata_beat[beat_idx];
                io_phase_next = PH_WDATA;
            end
            S_TURN:  io_phase_next = PH_READ;
            S_RDATA: io_phase_next = PH_READ;
            default: io_phase_next = PH_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_FETCH;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            beat_reg  <= beat_next;
        end
    end

    // Core inputs are only meaningful in EXEC; the rest of the sequence runs off these copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_addr_reg  <= '0;
            sh_wdata_reg <= '0;
            sh_r_reg     <= 1'b0;
            sh_w_reg     <= 1'b0;
        end else if (state_reg == S_EXEC) begin
            sh_addr_reg  <= mem_addr;
            sh_wdata_reg <= wr_data;
            sh_r_reg     <= mem_r;
            sh_w_reg     <= mem_w;
        end
    end

    // Outputs are a registered decode of the cycle just completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_reg       <= '0;
            rd_reg          <= '0;
            io_out_reg      <= '0;
            io_oe_reg       <= 1'b0;
            io_phase_reg    <= '0;
            io_beat_reg     <= '0;
            cpu_clk_reg     <= 1'b0;
            instr_valid_reg <= 1'b0;
            rd_valid_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            instr_reg       <= instr_next;
            rd_reg          <= rd_next;
            io_out_reg      <= io_out_next;
            io_oe_reg       <= (state_reg == S_ADDR) || (state_reg == S_WDATA);
            io_phase_reg    <= io_phase_next;
            io_beat_reg     <= beat_reg[CW-1:0];
            cpu_clk_reg     <= (state_reg == S_EXEC);
            instr_valid_reg <= (state_reg == S_FETCH) && last_beat;
            rd_valid_reg    <= (state_reg == S_RDATA) && last_beat;
            busy_reg        <= (state_reg != S_EXEC);
        end
    end

    assign io_out      = io_out_reg;
    assign io_oe       = io_oe_reg;
    assign io_phase    = io_phase_reg;
    assign io_beat     = io_beat_reg;
    assign cpu_clk     = cpu_clk_reg;
    assign instruction = instr_reg;
    assign instr_valid = instr_valid_reg;
    assign rd_data     = rd_reg;
    assign rd_valid    = rd_valid_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_io_bridge_param.sv
// Directed bench for io_bridge_param: default instance plus a 1-address-beat, no-turnaround instance.
module tb_io_bridge_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_b = 1'b1;
    logic [7:0]  io_in = '0;
    logic        mem_w = 1'b0, mem_r = 1'b0, flow_chg = 1'b0;
    logic [31:0] mem_addr = '0, wr_data = '0;

    logic [7:0]  io_out, io_out_b;
    logic        io_oe, io_oe_b;
    logic [1:0]  io_phase, io_phase_b;
    logic [2:0]  io_beat, io_beat_b;
    logic        cpu_clk, cpu_clk_b;
    logic [31:0] instruction, instruction_b;
    logic        instr_valid, instr_valid_b;
    logic [31:0] rd_data, rd_data_b;
    logic        rd_valid, rd_valid_b;
    logic        busy, busy_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    io_bridge_param dut (
        .clk(clk), .rst(rst), .io_in(io_in), .io_out(io_out), .io_oe(io_oe),
        .io_phase(io_phase), .io_beat(io_beat), .cpu_clk(cpu_clk),
        .mem_w(mem_w), .mem_r(mem_r), .flow_chg(flow_chg),
        .mem_addr(mem_addr), .wr_data(wr_data),
        .instruction(instruction), .instr_valid(instr_valid),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    io_bridge_param #(.ADDR_BEATS(1), .TURN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst_b), .io_in(io_in), .io_out(io_out_b), .io_oe(io_oe_b),
        .io_phase(io_phase_b), .io_beat(io_beat_b), .cpu_clk(cpu_clk_b),
        .mem_w(mem_w), .mem_r(mem_r), .flow_chg(flow_chg),
        .mem_addr(mem_addr), .wr_data(wr_data),
        .instruction(instruction_b), .instr_valid(instr_valid_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int k = 0; k < 4; k++) begin
            io_in = w[k*8 +: 8];
            tick();
            chk("fetch_phase", 32'(io_phase), 32'd0);
            chk("fetch_beat", 32'(io_beat), 32'(k));
            chk("fetch_oe", 32'(io_oe), 32'd0);
            chk("fetch_cpu_clk", 32'(cpu_clk), 32'd0);
            chk("fetch_rd_valid", 32'(rd_valid), 32'd0);
            chk("fetch_instr_valid", 32'(instr_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("instruction", instruction, word);
        $display("fetch     instr=0x%08h valid=%0d", instruction, instr_valid);
    endtask

    task automatic exec_step(input logic w, input logic r, input logic f,
                             input logic [31:0] addr, input logic [31:0] data);
        mem_w = w; mem_r = r; flow_chg = f; mem_addr = addr; wr_data = data;
        tick();
        chk("exec_cpu_clk", 32'(cpu_clk), 32'd1);
        chk("exec_busy", 32'(busy), 32'd0);
        chk("exec_oe", 32'(io_oe), 32'd0);
        chk("exec_instr_valid", 32'(instr_valid), 32'd0);
        $display("exec      w=%0d r=%0d f=%0d addr=0x%08h data=0x%08h", w, r, f, addr, data);
        // Scramble core inputs: the bridge must work from its shadow copies.
        mem_w = 1'b0; mem_r = 1'b0; flow_chg = 1'b0;
        mem_addr = 32'hFFFF_FFFF; wr_data = 32'h5A5A_5A5A;
    endtask

    task automatic step(input string tag, input logic [1:0] ph, input int bt,
                        input logic oe, input logic [7:0] out);
        tick();
        chk({tag, "_phase"}, 32'(io_phase), 32'(ph));
        chk({tag, "_beat"}, 32'(io_beat), 32'(bt));
        chk({tag, "_oe"}, 32'(io_oe), 32'(oe));
        chk({tag, "_out"}, 32'(io_out), 32'(out));
        $display("%s phase=%0d beat=%0d oe=%0d out=0x%02h", tag, io_phase, io_beat, io_oe, io_out);
    endtask

    task automatic addr_phase(input logic [31:0] addr);
        logic [31:0] a;
        a = addr;
        for (int k = 0; k < 4; k++) step("addr ", 2'b01, k, 1'b1, a[k*8 +: 8]);
    endtask

    task automatic rdata_phase(input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int k = 0; k < 4; k++) begin
            io_in = w[k*8 +: 8];
            tick();
            chk("rdata_phase", 32'(io_phase), 32'd3);
            chk("rdata_beat", 32'(io_beat), 32'(k));
            chk("rdata_oe", 32'(io_oe), 32'd0);
            chk("rdata_rd_valid", 32'(rd_valid), (k == 3) ? 32'd1 : 32'd0);
        end
        chk("rd_data", rd_data, word);
        $display("rdata     rd_data=0x%08h valid=%0d", rd_data, rd_valid);
    endtask

    initial begin
        logic [31:0] wd;

        // Reset state
        tick();
        tick();
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_io_out", 32'(io_out), 32'd0);
        chk("rst_oe", 32'(io_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cpu_clk", 32'(cpu_clk), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        $display("reset     outputs cleared");
        rst = 1'b0;

        // T1: fetch 0x12345678, valid on 4th cycle, cpu_clk on 5th
        fetch(32'h1234_5678);
        exec_step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // T2: ALU loop, FETCH restarts immediately
        fetch(32'hAABB_CCDD);
        exec_step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(32'h0123_4567);

        // T3: store
        exec_step(1'b1, 1'b0, 1'b0, 32'h0000_00A4, 32'hDEAD_BEEF);
        addr_phase(32'h0000_00A4);
        wd = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) step("wdata", 2'b10, k, 1'b1, wd[k*8 +: 8]);

        // T4: load with one turnaround cycle
        fetch(32'h8C01_0010);
        exec_step(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        addr_phase(32'h0000_0010);
        step("turn ", 2'b11, 0, 1'b0, 8'h00);
        rdata_phase(32'h1122_3344);

        // Write-verify: store then read back the same address
        fetch(32'hAC22_0020);
        chk("rd_data_hold", rd_data, 32'h1122_3344);
        exec_step(1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'h0102_0304);
        addr_phase(32'h0000_0020);
        wd = 32'h0102_0304;
        for (int k = 0; k < 4; k++) step("wdata", 2'b10, k, 1'b1, wd[k*8 +: 8]);
        step("turn ", 2'b11, 0, 1'b0, 8'h00);
        rdata_phase(32'h0102_0304);

        // Flow change only: address is the new PC, then straight back to FETCH
        fetch(32'h0800_0100);
        exec_step(1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'h0);
        addr_phase(32'h0000_0400);

        // Flow change with a load: one address phase, then the read
        fetch(32'h1000_0003);
        exec_step(1'b0, 1'b1, 1'b1, 32'h0000_0030, 32'h0);
        addr_phase(32'h0000_0030);
        step("turn ", 2'b11, 0, 1'b0, 8'h00);
        rdata_phase(32'hCAFE_F00D);

        // T6: reset during beat 2 of WDATA
        fetch(32'hAC00_0040);
        exec_step(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h7766_5544);
        addr_phase(32'h0000_0040);
        step("wdata", 2'b10, 0, 1'b1, 8'h44);
        step("wdata", 2'b10, 1, 1'b1, 8'h55);
        rst = 1'b1;
        #1;
        chk("midrst_io_out", 32'(io_out), 32'd0);
        chk("midrst_oe", 32'(io_oe), 32'd0);
        chk("midrst_phase", 32'(io_phase), 32'd0);
        chk("midrst_instruction", instruction, 32'd0);
        chk("midrst_rd_data", rd_data, 32'd0);
        $display("midreset  outputs cleared");
        tick();
        rst = 1'b0;
        io_in = 8'h00;
        chk("post_rst_instruction", instruction, 32'd0);
        tick();
        chk("post_rst_phase", 32'(io_phase), 32'd0);
        chk("post_rst_beat", 32'(io_beat), 32'd0);
        chk("post_rst_oe", 32'(io_oe), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd1);
        $display("postreset phase=%0d beat=%0d", io_phase, io_beat);

        // T5: ADDR_BEATS=1, TURN_CYCLES=0 instance, load -> 10 cycles
        rst = 1'b1;
        rst_b = 1'b0;
        wd = 32'h8C55_0000;
        for (int k = 0; k < 4; k++) begin
            io_in = wd[k*8 +: 8];
            tick();
            chk("b_fetch_phase", 32'(io_phase_b), 32'd0);
            chk("b_fetch_beat", 32'(io_beat_b), 32'(k));
        end
        chk("b_instruction", instruction_b, 32'h8C55_0000);
        chk("b_instr_valid", 32'(instr_valid_b), 32'd1);
        mem_r = 1'b1; mem_addr = 32'h0000_0055;
        tick();
        chk("b_exec_cpu_clk", 32'(cpu_clk_b), 32'd1);
        mem_r = 1'b0; mem_addr = 32'hFFFF_FFFF;
        tick();
        chk("b_addr_phase", 32'(io_phase_b), 32'd1);
        chk("b_addr_out", 32'(io_out_b), 32'h55);
        chk("b_addr_oe", 32'(io_oe_b), 32'd1);
        $display("b_addr    out=0x%02h phase=%0d", io_out_b, io_phase_b);
        wd = 32'h9988_7766;
        for (int k = 0; k < 4; k++) begin
            io_in = wd[k*8 +: 8];
            tick();
            chk("b_rdata_phase", 32'(io_phase_b), 32'd3);
            chk("b_rdata_oe", 32'(io_oe_b), 32'd0);
        end
        chk("b_rd_data", rd_data_b, 32'h9988_7766);
        chk("b_rd_valid", 32'(rd_valid_b), 32'd1);
        $display("b_rdata   rd_data=0x%08h", rd_data_b);
        tick();
        chk("b_refetch_phase", 32'(io_phase_b), 32'd0);
        chk("b_refetch_beat", 32'(io_beat_b), 32'd0);
        chk("b_refetch_rd_valid", 32'(rd_valid_b), 32'd0);
        $display("b_refetch phase=%0d beat=%0d", io_phase_b, io_beat_b);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
